// File: rtl/cnt_state_driver.sv
// cnt_state_driver: sequential driver and checker around the combinational counter next-state slice.
module cnt_state_driver #(
  parameter int         W          = 10,
  parameter logic [8:0] SEL_CODE   = 9'h1EC,
  parameter logic [8:0] SEL_IDLE   = 9'h000,
  parameter logic [9:0] MODE_RUN   = 10'h0C2,
  parameter logic [9:0] MODE_BLOCK = 10'h0C1,
  parameter int         MAXRUN     = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [W-1:0] sl_state,
  output logic [8:0]   sl_sel,
  output logic [9:0]   sl_mode,
  output logic         sl_en,
  output logic         sl_clr,
  input  logic [W-1:0] sl_next
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STEP  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_BLK   = 3'd5;
  logic [1:0]   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] cnt_q, cnt_d, data_q, data_d, pred;
  logic         err_q, err_d, act, inc;
  assign inc  = op_q == OP_STEP || op_q == OP_RUN;
  assign pred = op_q == OP_CLEAR ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  // Slice fields are held across DRIVE and CAPT so sl_next is settled when captured; LOAD never touches the slice.
  assign act       = (state_q == DRIVE || state_q == CAPT) && op_q != OP_LOAD;
  assign sl_sel    = act && op_q != OP_CLEAR ? SEL_CODE : SEL_IDLE;
  assign sl_mode   = act && inc ? MODE_RUN : MODE_BLOCK;
  assign sl_en     = act && (inc || op_q == OP_BLK);
  assign sl_clr    = act && op_q == OP_CLEAR;
  assign sl_state  = cnt_q;
  assign req_ready = state_q == IDLE && !rst;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = cnt_q;
  assign rsp_err   = err_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d    = req_op;
        data_d  = req_op == OP_RUN && req_data > W'(MAXRUN) ? W'(MAXRUN) : req_data;
        err_d   = req_op > 3'd5;
        state_d = req_op > 3'd5 || (req_op == OP_RUN && req_data == '0) ? RESP : DRIVE;
      end
      DRIVE: begin
        cnt_d   = op_q == OP_LOAD ? data_q : cnt_q;
        state_d = op_q == OP_LOAD ? RESP : CAPT;
      end
      CAPT: begin
        cnt_d   = sl_next;
        err_d   = err_q || sl_next != pred;
        data_d  = op_q == OP_RUN ? data_q - W'(1) : data_q;
        state_d = op_q == OP_RUN && data_q != W'(1) ? DRIVE : RESP;
      end
      default: if (rsp_ready) begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_cnt_state_driver.sv
// tb_cnt_state_driver: scoreboard bench for cnt_state_driver with a behavioural slice and command model.
module tb_cnt_state_driver;
  localparam logic [8:0] SEL_CODE   = 9'h1EC;
  localparam logic [8:0] SEL_IDLE   = 9'h000;
  localparam logic [9:0] MODE_RUN   = 10'h0C2;
  localparam logic [9:0] MODE_BLOCK = 10'h0C1;
  logic       clk = 0, rst = 1;
  logic       req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err, sl_en, sl_clr;
  logic [2:0] req_op = 0;
  logic [9:0] req_data = 0, rsp_data, sl_state, sl_mode, sl_next;
  logic [8:0] sl_sel;
  typedef struct {logic [9:0] d; logic e; int hs; int lat;} exp_t;
  exp_t q[$];
  int vec = 0, bad = 0, cyc = 0, fault = 0, rdy_mode = 0, en_cnt = 0, clr_cnt = 0;
  logic [9:0] m_cnt = 0;

  cnt_state_driver dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sl_state(sl_state), .sl_sel(sl_sel), .sl_mode(sl_mode), .sl_en(sl_en),
    .sl_clr(sl_clr), .sl_next(sl_next)
  );

  // Slice: clear wins, increments only when selected, enabled and in run mode; faults 1/2 model broken slices.
  assign sl_next = fault == 2 ? 10'd1 : sl_clr ? 10'd0 :
                   (sl_sel == SEL_CODE && sl_en && (sl_mode == MODE_RUN || fault == 1)) ? sl_state + 10'd1 : sl_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [9:0] d);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 5000) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    e.e = 0; e.lat = 3; e.hs = cyc;
    case (op)
      0: begin m_cnt = d; e.lat = 2; end
      1: m_cnt = m_cnt + 10'd1;
      2: begin m_cnt = m_cnt + d; e.lat = d == 0 ? 1 : 1 + 2 * int'(d); end
      3: ;
      4: begin m_cnt = fault == 2 ? 10'd1 : 10'd0; e.e = fault == 2; end
      5: if (fault == 1) begin m_cnt = m_cnt + 10'd1; e.e = 1; end
      default: begin e.e = 1; e.lat = 1; end
    endcase
    e.d = m_cnt;
    q.push_back(e);
    req_valid = 1; req_op = op; req_data = d;
    @(posedge clk);
    #1 req_valid = 0; req_op = 3'($urandom); req_data = 10'($urandom);
  endtask

  task automatic wait_q();
    int t = 0;
    while (q.size() != 0 && t < 4000) begin @(negedge clk); t++; end
    if (q.size() != 0) begin
      vec++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_sl_state", sl_state, 0);
    chk("rst_sl_sel", sl_sel, SEL_IDLE);
    chk("rst_sl_mode", sl_mode, MODE_BLOCK);
    chk("rst_sl_en", sl_en, 0);
    chk("rst_sl_clr", sl_clr, 0);
  endtask

  // Monitor: drives rsp_ready, checks latency on first sight, stability while held, and content on acceptance.
  initial begin
    bit seen = 0;
    logic [9:0] hd;
    logic he;
    forever begin
      @(negedge clk);
      rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom) : 1'b0;
      if (sl_en) en_cnt++;
      if (sl_clr) clr_cnt++;
      if (rst) seen = 0;
      else if (rsp_valid) begin
        if (!seen) begin
          seen = 1; hd = rsp_data; he = rsp_err;
          if (q.size() == 0) begin
            vec++; bad++;
            $display("FAIL unexpected_rsp: data 0x%0h err %0d with nothing outstanding", rsp_data, rsp_err);
          end else chk("latency", cyc - q[0].hs, q[0].lat);
        end else begin
          chk("rsp_stable_data", rsp_data, hd);
          chk("rsp_stable_err", rsp_err, he);
          chk("req_ready_in_resp", req_ready, 0);
        end
        if (rsp_ready) begin
          if (q.size() != 0) begin
            chk("rsp_data", rsp_data, q[0].d);
            chk("rsp_err", rsp_err, q[0].e);
            void'(q.pop_front());
          end
          seen = 0;
        end
      end
    end
  end

  initial begin
    #2 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 0;
    issue(0, 10'h155);
    issue(3, 0);
    @(negedge clk);
    chk("read_drive_sel", sl_sel, SEL_CODE);
    chk("read_drive_en", sl_en, 0);
    wait_q();
    issue(0, 10'h3FE);
    wait_q();
    en_cnt = 0;
    issue(2, 10'd3);
    wait_q();
    chk("run3_en_cycles", en_cnt, 6);
    issue(5, 0);
    wait_q();
    fault = 1;
    issue(5, 0);
    wait_q();
    fault = 0;
    issue(0, 10'h2A0);
    wait_q();
    clr_cnt = 0;
    issue(4, 0);
    wait_q();
    chk("clear_clr_cycles", clr_cnt, 2);
    fault = 2;
    issue(4, 0);
    wait_q();
    fault = 0;
    rdy_mode = 2;
    issue(6, 10'($urandom));
    repeat (6) @(negedge clk);
    rdy_mode = 0;
    wait_q();
    issue(0, 10'h0AB);
    wait_q();
    issue(2, 10'd100);
    repeat (80) @(posedge clk);
    #3 rst = 1;
    #1 chk_reset_outputs();
    q.delete();
    m_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("no_rsp_after_reset", rsp_valid, 0);
    issue(3, 0);
    wait_q();
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, op == 2 ? 10'($urandom_range(0, 12)) : 10'($urandom));
    end
    wait_q();
    rdy_mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
